// File: rtl/kpn_pkg.sv
// Shared definitions for KPN process nodes and their queues.
package kpn_pkg;

    localparam int unsigned BITS_NUMBER_DEF = 16;
    localparam int unsigned COUNT_BITS_DEF  = 16;

    typedef enum logic [1:0] {
        READ_A  = 2'd0,
        READ_B  = 2'd1,
        COMPUTE = 2'd2,
        WRITE   = 2'd3
    } kpn_state_e;

endpackage

// File: rtl/kpn_fifo_reader.sv
// Blocking-read handshake: pops one token when enabled and the queue is non-empty,
// capturing the head token on the same edge the queue advances.
module kpn_fifo_reader
    import kpn_pkg::*;
#(
    parameter int unsigned W = BITS_NUMBER_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         empty_i,
    input  logic [W-1:0] entry_i,
    output logic         rd_o,
    output logic         got_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;

    // Pop strobe follows the empty flag combinationally while enabled.
    assign rd_o   = en_i & ~empty_i;
    assign got_o  = rd_o;
    assign data_o = data_q;

    // Capture the head token in the cycle it is popped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (rd_o) begin
            data_q <= entry_i;
        end
    end

endmodule

// File: rtl/kpn_adder_process.sv
// KPN adder node: reads one token from each input queue (queue 1 first), adds them
// and writes the sum downstream. Define KPN_ADDER_SATURATE_EN for a saturating add.
module kpn_adder_process
    import kpn_pkg::*;
#(
    parameter int unsigned BITS_NUMBER = BITS_NUMBER_DEF,
    parameter int unsigned COUNT_BITS  = COUNT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [BITS_NUMBER-1:0] entry_1,
    input  logic                   empty_1,
    output logic                   rd_1,
    input  logic [BITS_NUMBER-1:0] entry_2,
    input  logic                   empty_2,
    output logic                   rd_2,
    input  logic                   full_out,
    output logic                   wr,
    output logic [BITS_NUMBER-1:0] output_1,
    output logic                   busy,
    output logic [COUNT_BITS-1:0]  token_count
);

    kpn_state_e             state_q, state_d;
    logic [BITS_NUMBER-1:0] op_a, op_b;
    logic [BITS_NUMBER-1:0] sum_q, sum_d;
    logic [COUNT_BITS-1:0]  count_q;
    logic                   got_a, got_b;
    logic                   en_a, en_b;

    // Strobes are suppressed while reset is asserted.
    assign en_a = reset_n & (state_q == READ_A);
    assign en_b = reset_n & (state_q == READ_B);
    assign wr   = reset_n & (state_q == WRITE) & ~full_out;

    kpn_fifo_reader #(.W(BITS_NUMBER)) u_reader_a (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_a),
        .empty_i (empty_1),
        .entry_i (entry_1),
        .rd_o    (rd_1),
        .got_o   (got_a),
        .data_o  (op_a)
    );

    kpn_fifo_reader #(.W(BITS_NUMBER)) u_reader_b (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_b),
        .empty_i (empty_2),
        .entry_i (entry_2),
        .rd_o    (rd_2),
        .got_o   (got_b),
        .data_o  (op_b)
    );

`ifdef KPN_ADDER_SATURATE_EN
    logic [BITS_NUMBER:0] sum_full;

    // Unsigned saturating add: a carry out clamps to all ones.
    always_comb begin
        sum_full = (BITS_NUMBER+1)'(op_a) + (BITS_NUMBER+1)'(op_b);
        sum_d    = sum_full[BITS_NUMBER] ? '1 : sum_full[BITS_NUMBER-1:0];
    end
`else
    // Wrap-around add, modulo 2^BITS_NUMBER.
    always_comb begin
        sum_d = op_a + op_b;
    end
`endif

    // Next-state logic for one firing: read A, read B, add, write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            READ_A:  if (got_a) state_d = READ_B;
            READ_B:  if (got_b) state_d = COMPUTE;
            COMPUTE: state_d = WRITE;
            WRITE:   if (wr) state_d = READ_A;
            default: state_d = READ_A;
        endcase
    end

    // State, sum and fired-token counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= READ_A;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == COMPUTE) begin
                sum_q <= sum_d;
            end
            if (wr) begin
                count_q <= count_q + COUNT_BITS'(1);
            end
        end
    end

    assign output_1    = sum_q;
    assign busy        = (state_q != READ_A);
    assign token_count = count_q;

endmodule

// File: tb/tb_kpn_adder_process.sv
// Self-checking bench for kpn_adder_process (counter narrowed to 4 bits).
module tb_kpn_adder_process;

    localparam int unsigned W  = 16;
    localparam int unsigned CB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  entry_1, entry_2;
    logic          empty_1, empty_2;
    logic          rd_1, rd_2;
    logic          full_out;
    logic          wr;
    logic [W-1:0]  output_1;
    logic          busy;
    logic [CB-1:0] token_count;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    kpn_adder_process #(.BITS_NUMBER(W), .COUNT_BITS(CB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .entry_1     (entry_1),
        .empty_1     (empty_1),
        .rd_1        (rd_1),
        .entry_2     (entry_2),
        .empty_2     (empty_2),
        .rd_2        (rd_2),
        .full_out    (full_out),
        .wr          (wr),
        .output_1    (output_1),
        .busy        (busy),
        .token_count (token_count)
    );

    always #5 clk = ~clk;

    // Reference sum of two tokens.
    function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
`ifdef KPN_ADDER_SATURATE_EN
        if (s > 32'd65535) return 16'hFFFF;
`endif
        return 16'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; empty_1 = 1'b1; empty_2 = 1'b1; full_out = 1'b0;
        entry_1 = '0; entry_2 = '0;
        step(); step();
        reset_n = 1'b1;
        model_count = 0;
    endtask

    // Drives one unstalled firing starting in READ_A.
    task automatic fire(input logic [W-1:0] a, input logic [W-1:0] b);
        empty_1 = 1'b0; entry_1 = a; empty_2 = 1'b1; full_out = 1'b0; step();
        empty_1 = 1'b1; empty_2 = 1'b0; entry_2 = b; step();
        empty_2 = 1'b1; step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0; full_out = 1'b0;
        entry_1 = 16'h1234; entry_2 = 16'h5678;
        step(); step(); step();
        checks++;
        if ({rd_1, rd_2, wr} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=000", {rd_1, rd_2, wr});
        end
        checks++;
        if (output_1 !== 16'h0 || token_count !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state out=%h cnt=%h busy=%b exp 0/0/0", output_1, token_count, busy);
        end
        empty_1 = 1'b1; empty_2 = 1'b1;
        reset_n = 1'b1;
        model_count = 0;
    endtask

    task automatic test_steady();
        do_reset();
        entry_1 = 16'h0003; entry_2 = 16'h0004;
        empty_1 = 1'b0; empty_2 = 1'b0; full_out = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rd_1 !== (c == 0) || rd_2 !== (c == 1) || wr !== (c == 3) || busy !== (c != 0)) begin
                errors++;
                $display("FAIL steady_cycle%0d rd1=%b rd2=%b wr=%b busy=%b", c, rd_1, rd_2, wr, busy);
            end
            if (c == 3) begin
                checks++;
                if (output_1 !== 16'h0007) begin
                    errors++; $display("FAIL steady_sum got=%h exp=0007", output_1);
                end
            end
            step();
        end
        empty_1 = 1'b1; empty_2 = 1'b1;
        model_count++;
        #1;
        checks++;
        if (token_count !== 4'd1 || output_1 !== 16'h0007) begin
            errors++; $display("FAIL steady_count cnt=%0d out=%h exp 1/0007", token_count, output_1);
        end
    endtask

    task automatic test_empty_stall();
        logic [W-1:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        empty_1 = 1'b0; entry_1 = a; empty_2 = 1'b1; full_out = 1'b0;
        #1;
        checks++;
        if (rd_1 !== 1'b1) begin errors++; $display("FAIL estall_rd1 got=%b exp=1", rd_1); end
        step();
        empty_1 = 1'b1; entry_1 = 16'($urandom);
        repeat (5) begin
            #1;
            checks++;
            if (rd_1 !== 1'b0 || rd_2 !== 1'b0 || wr !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL estall_hold rd1=%b rd2=%b wr=%b busy=%b exp 0/0/0/1", rd_1, rd_2, wr, busy);
            end
            step();
        end
        empty_2 = 1'b0; entry_2 = b;
        #1;
        checks++;
        if (rd_2 !== 1'b1) begin errors++; $display("FAIL estall_rd2 got=%b exp=1", rd_2); end
        step();
        empty_2 = 1'b1; entry_2 = 16'($urandom);
        #1;
        checks++;
        if ({rd_1, rd_2, wr} !== 3'b000) begin
            errors++; $display("FAIL estall_compute strobes=%b exp=000", {rd_1, rd_2, wr});
        end
        step();
        #1;
        checks++;
        if (wr !== 1'b1 || output_1 !== model_add(a, b)) begin
            errors++; $display("FAIL estall_sum wr=%b out=%h exp 1/%h", wr, output_1, model_add(a, b));
        end
        step();
        model_count++;
        checks++;
        if (token_count !== CB'(model_count)) begin
            errors++; $display("FAIL estall_count got=%0d exp=%0d", token_count, CB'(model_count));
        end
    endtask

    task automatic test_full_stall();
        logic [W-1:0] a, b, s;
        a = 16'($urandom); b = 16'($urandom); s = model_add(a, b);
        empty_1 = 1'b0; entry_1 = a; empty_2 = 1'b1; full_out = 1'b0; step();
        empty_1 = 1'b1; empty_2 = 1'b0; entry_2 = b; step();
        empty_2 = 1'b1; full_out = 1'b1; step();
        repeat (6) begin
            #1;
            checks++;
            if (wr !== 1'b0 || output_1 !== s || token_count !== CB'(model_count) || busy !== 1'b1) begin
                errors++;
                $display("FAIL fstall_hold wr=%b out=%h cnt=%0d exp 0/%h/%0d", wr, output_1, token_count, s, CB'(model_count));
            end
            step();
        end
        full_out = 1'b0;
        #1;
        checks++;
        if (wr !== 1'b1 || output_1 !== s) begin
            errors++; $display("FAIL fstall_release wr=%b out=%h exp 1/%h", wr, output_1, s);
        end
        step();
        model_count++;
        #1;
        checks++;
        if (wr !== 1'b0 || token_count !== CB'(model_count)) begin
            errors++; $display("FAIL fstall_after wr=%b cnt=%0d exp 0/%0d", wr, token_count, CB'(model_count));
        end
    endtask

    task automatic test_wrap_saturate();
        fire(16'hFFF0, 16'h0020);
        model_count++;
        #1;
        checks++;
        if (output_1 !== model_add(16'hFFF0, 16'h0020) || token_count !== CB'(model_count)) begin
            errors++;
            $display("FAIL wrap_sat out=%h cnt=%0d exp %h/%0d", output_1, token_count, model_add(16'hFFF0, 16'h0020), CB'(model_count));
        end
        fire(16'h7FFF, 16'h8000);
        model_count++;
        #1;
        checks++;
        if (output_1 !== 16'hFFFF) begin
            errors++; $display("FAIL edge_sum out=%h exp=ffff", output_1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        fire(16'h0001, 16'h0002);
        model_count++;
        empty_1 = 1'b0; entry_1 = 16'h0005; step();
        empty_1 = 1'b1; empty_2 = 1'b0; entry_2 = 16'h0006; step();
        reset_n = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
        #1;
        checks++;
        if ({rd_1, rd_2, wr} !== 3'b000) begin
            errors++; $display("FAIL midrst_strobes got=%b exp=000", {rd_1, rd_2, wr});
        end
        step();
        checks++;
        if ({rd_1, rd_2, wr} !== 3'b000 || output_1 !== 16'h0 || token_count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state strobes=%b out=%h cnt=%0d busy=%b exp 000/0/0/0", {rd_1, rd_2, wr}, output_1, token_count, busy);
        end
        reset_n = 1'b1; model_count = 0;
        empty_1 = 1'b1; empty_2 = 1'b1;
        fire(16'h0011, 16'h0022);
        model_count++;
        #1;
        checks++;
        if (output_1 !== 16'h0033 || token_count !== CB'(model_count)) begin
            errors++; $display("FAIL midrst_fresh out=%h cnt=%0d exp 0033/%0d", output_1, token_count, CB'(model_count));
        end
    endtask

    // Random stalls on both inputs and the output; 17 firings wrap the 4-bit counter to 1.
    task automatic test_random_flow();
        localparam int N = 17;
        logic [W-1:0] a [N];
        logic [W-1:0] b [N];
        int i1, i2, k, cyc;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i] = 16'($urandom); b[i] = 16'($urandom);
        end
        a[3] = 16'hFFF0; b[3] = 16'h0020;
        i1 = 0; i2 = 0; k = 0; cyc = 0;
        while (k < N && cyc < 2000) begin
            empty_1  = (i1 >= N) || ($urandom_range(0, 3) == 0);
            empty_2  = (i2 >= N) || ($urandom_range(0, 3) == 0);
            entry_1  = empty_1 ? 16'($urandom) : a[i1];
            entry_2  = empty_2 ? 16'($urandom) : b[i2];
            full_out = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if ((rd_1 && rd_2) || (rd_1 && wr) || (rd_2 && wr) ||
                (rd_1 && empty_1) || (rd_2 && empty_2) || (wr && full_out)) begin
                errors++;
                $display("FAIL rand_handshake cyc=%0d rd1=%b rd2=%b wr=%b e1=%b e2=%b full=%b", cyc, rd_1, rd_2, wr, empty_1, empty_2, full_out);
            end
            checks++;
            if (token_count !== CB'(k)) begin
                errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, token_count, CB'(k));
            end
            if (rd_2) begin
                checks++;
                if (i2 >= i1) begin
                    errors++; $display("FAIL rand_order cyc=%0d q2_pops=%0d q1_pops=%0d", cyc, i2 + 1, i1);
                end
                i2++;
            end
            if (rd_1) i1++;
            if (wr) begin
                checks++;
                if (k >= i2 || output_1 !== model_add(a[k], b[k])) begin
                    errors++; $display("FAIL rand_sum idx=%0d got=%h exp=%h", k, output_1, model_add(a[k], b[k]));
                end
                k++;
            end
            step();
            cyc++;
        end
        empty_1 = 1'b1; empty_2 = 1'b1; full_out = 1'b0;
        checks++;
        if (k != N) begin
            errors++; $display("FAIL rand_timeout written=%0d exp=%0d", k, N);
        end
        #1;
        checks++;
        if (token_count !== 4'd1) begin
            errors++; $display("FAIL counter_wrap got=%0d exp=1", token_count);
        end
    endtask

    initial begin
        reset_n = 1'b0; empty_1 = 1'b1; empty_2 = 1'b1; full_out = 1'b0;
        entry_1 = '0; entry_2 = '0;
        #1;
        test_reset();
        test_steady();
        test_empty_stall();
        test_full_stall();
        test_wrap_saturate();
        test_mid_reset();
        test_random_flow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
